// File: rtl/axi_reg_slice.sv
// AXI register slice: five independent channel cells between axis and axim.
// Each cell is a wire, a forward register or a two-entry skid buffer.

module axi_reg_slice_cell #(
  parameter int P_WIDTH = 1,
  parameter int P_MODE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [P_WIDTH-1:0] src_data,
  output logic               snk_valid,
  input  logic               snk_ready,
  output logic [P_WIDTH-1:0] snk_data
);

  if (P_MODE == 0) begin : g_wire
    logic unused;
    assign unused    = &{1'b0, clk, rst_n};
    assign snk_valid = src_valid;
    assign snk_data  = src_data;
    assign src_ready = snk_ready;
  end else if (P_MODE == 2) begin : g_fwd
    logic               vld;
    logic [P_WIDTH-1:0] data_q;
    logic               push;

    assign src_ready = !vld || snk_ready;
    assign push      = src_valid && src_ready;
    assign snk_valid = vld;
    assign snk_data  = data_q;

    // valid flag: set on load, clear on drain
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         vld <= 1'b0;
      else if (push)      vld <= 1'b1;
      else if (snk_ready) vld <= 1'b0;
    end

    // payload capture, no reset needed
    always_ff @(posedge clk) begin
      if (push) data_q <= src_data;
    end
  end else if (P_MODE == 1) begin : g_skid
    // bit0 = sink valid, bit1 = full (source ready low)
    typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
    } state_e;

    state_e             state;
    state_e             state_nxt;
    logic               push;
    logic               pop;
    logic               main_ld;
    logic               main_sel;
    logic               skid_ld;
    logic [P_WIDTH-1:0] main_q;
    logic [P_WIDTH-1:0] skid_q;

    assign src_ready = ~state[1];
    assign snk_valid = state[0];
    assign snk_data  = main_q;
    assign push      = src_valid & src_ready;
    assign pop       = snk_valid & snk_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
      state_nxt = state;
      case (state)
        EMPTY: if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = FULL;
          else if (!push && pop) state_nxt = EMPTY;
        end
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end

    // datapath load strobes decoded from state
    always_comb begin
      main_ld  = 1'b0;
      main_sel = 1'b0;
      skid_ld  = 1'b0;
      case (state)
        EMPTY: main_ld = push;
        ONE: begin
          main_ld = push & pop;
          skid_ld = push & ~pop;
        end
        FULL: begin
          main_ld  = pop;
          main_sel = pop;
        end
        default: ;
      endcase
    end

    // main and skid payload registers, no reset needed
    always_ff @(posedge clk) begin
      if (main_ld) main_q <= main_sel ? skid_q : src_data;
      if (skid_ld) skid_q <= src_data;
    end
  end else begin : g_bad
    $error("axi_reg_slice_cell: P_MODE must be 0, 1 or 2");
    logic unused;
    assign unused    = &{1'b0, clk, rst_n, src_valid, src_data, snk_ready};
    assign snk_valid = 1'b0;
    assign snk_data  = '0;
    assign src_ready = 1'b0;
  end

endmodule

module axi_reg_slice #(
  parameter int P_AXI_IDWIDTH   = 5,
  parameter int P_AXI_AWIDTH    = 32,
  parameter int P_AXI_DWIDTH    = 64,
  parameter int P_AXI_USERWIDTH = 1,
  parameter int P_AW_MODE       = 1,
  parameter int P_W_MODE        = 1,
  parameter int P_B_MODE        = 1,
  parameter int P_AR_MODE       = 1,
  parameter int P_R_MODE        = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [P_AXI_AWIDTH-1:0]    axis_awaddr,
  input  logic [7:0]                 axis_awlen,
  input  logic [2:0]                 axis_awsize,
  input  logic [1:0]                 axis_awburst,
  input  logic [P_AXI_IDWIDTH-1:0]   axis_awid,
  input  logic                       axis_awlock,
  input  logic [3:0]                 axis_awcache,
  input  logic [2:0]                 axis_awprot,
  input  logic [P_AXI_USERWIDTH-1:0] axis_awuser,
  input  logic                       axis_awvalid,
  output logic                       axis_awready,
  input  logic [P_AXI_IDWIDTH-1:0]   axis_wid,
  input  logic [P_AXI_DWIDTH-1:0]    axis_wdata,
  input  logic [P_AXI_DWIDTH/8-1:0]  axis_wstrb,
  input  logic                       axis_wlast,
  input  logic [P_AXI_USERWIDTH-1:0] axis_wuser,
  input  logic                       axis_wvalid,
  output logic                       axis_wready,
  output logic [P_AXI_IDWIDTH-1:0]   axis_bid,
  output logic [1:0]                 axis_bresp,
  output logic [P_AXI_USERWIDTH-1:0] axis_buser,
  output logic                       axis_bvalid,
  input  logic                       axis_bready,
  input  logic [P_AXI_IDWIDTH-1:0]   axis_arid,
  input  logic [P_AXI_AWIDTH-1:0]    axis_araddr,
  input  logic [7:0]                 axis_arlen,
  input  logic [2:0]                 axis_arsize,
  input  logic [1:0]                 axis_arburst,
  input  logic                       axis_arlock,
  input  logic [3:0]                 axis_arcache,
  input  logic [2:0]                 axis_arprot,
  input  logic [P_AXI_USERWIDTH-1:0] axis_aruser,
  input  logic                       axis_arvalid,
  output logic                       axis_arready,
  output logic [P_AXI_IDWIDTH-1:0]   axis_rid,
  output logic [P_AXI_DWIDTH-1:0]    axis_rdata,
  output logic [1:0]                 axis_rresp,
  output logic                       axis_rlast,
  output logic [P_AXI_USERWIDTH-1:0] axis_ruser,
  output logic                       axis_rvalid,
  input  logic                       axis_rready,
  output logic [P_AXI_AWIDTH-1:0]    axim_awaddr,
  output logic [7:0]                 axim_awlen,
  output logic [2:0]                 axim_awsize,
  output logic [1:0]                 axim_awburst,
  output logic [P_AXI_IDWIDTH-1:0]   axim_awid,
  output logic                       axim_awlock,
  output logic [3:0]                 axim_awcache,
  output logic [2:0]                 axim_awprot,
  output logic [P_AXI_USERWIDTH-1:0] axim_awuser,
  output logic                       axim_awvalid,
  input  logic                       axim_awready,
  output logic [P_AXI_IDWIDTH-1:0]   axim_wid,
  output logic [P_AXI_DWIDTH-1:0]    axim_wdata,
  output logic [P_AXI_DWIDTH/8-1:0]  axim_wstrb,
  output logic                       axim_wlast,
  output logic [P_AXI_USERWIDTH-1:0] axim_wuser,
  output logic                       axim_wvalid,
  input  logic                       axim_wready,
  input  logic [P_AXI_IDWIDTH-1:0]   axim_bid,
  input  logic [1:0]                 axim_bresp,
  input  logic [P_AXI_USERWIDTH-1:0] axim_buser,
  input  logic                       axim_bvalid,
  output logic                       axim_bready,
  output logic [P_AXI_IDWIDTH-1:0]   axim_arid,
  output logic [P_AXI_AWIDTH-1:0]    axim_araddr,
  output logic [7:0]                 axim_arlen,
  output logic [2:0]                 axim_arsize,
  output logic [1:0]                 axim_arburst,
  output logic                       axim_arlock,
  output logic [3:0]                 axim_arcache,
  output logic [2:0]                 axim_arprot,
  output logic [P_AXI_USERWIDTH-1:0] axim_aruser,
  output logic                       axim_arvalid,
  input  logic                       axim_arready,
  input  logic [P_AXI_IDWIDTH-1:0]   axim_rid,
  input  logic [P_AXI_DWIDTH-1:0]    axim_rdata,
  input  logic [1:0]                 axim_rresp,
  input  logic                       axim_rlast,
  input  logic [P_AXI_USERWIDTH-1:0] axim_ruser,
  input  logic                       axim_rvalid,
  output logic                       axim_rready
);

  localparam int IW = P_AXI_IDWIDTH;
  localparam int UW = P_AXI_USERWIDTH;
  localparam int DW = P_AXI_DWIDTH;
  localparam int AXW = P_AXI_AWIDTH + 8 + 3 + 2 + IW + 1 + 4 + 3 + UW;
  localparam int WW = IW + DW + DW / 8 + 1 + UW;
  localparam int BW = IW + 2 + UW;
  localparam int RW = IW + DW + 2 + 1 + UW;

  logic [AXW-1:0] aw_src, aw_snk, ar_src, ar_snk;
  logic [WW-1:0]  w_src, w_snk;
  logic [BW-1:0]  b_src, b_snk;
  logic [RW-1:0]  r_src, r_snk;

  assign aw_src = {axis_awaddr, axis_awlen, axis_awsize, axis_awburst,
                   axis_awid, axis_awlock, axis_awcache, axis_awprot,
                   axis_awuser};
  assign {axim_awaddr, axim_awlen, axim_awsize, axim_awburst,
          axim_awid, axim_awlock, axim_awcache, axim_awprot,
          axim_awuser} = aw_snk;

  assign w_src = {axis_wid, axis_wdata, axis_wstrb, axis_wlast, axis_wuser};
  assign {axim_wid, axim_wdata, axim_wstrb, axim_wlast, axim_wuser} = w_snk;

  assign b_src = {axim_bid, axim_bresp, axim_buser};
  assign {axis_bid, axis_bresp, axis_buser} = b_snk;

  assign ar_src = {axis_araddr, axis_arlen, axis_arsize, axis_arburst,
                   axis_arid, axis_arlock, axis_arcache, axis_arprot,
                   axis_aruser};
  assign {axim_araddr, axim_arlen, axim_arsize, axim_arburst,
          axim_arid, axim_arlock, axim_arcache, axim_arprot,
          axim_aruser} = ar_snk;

  assign r_src = {axim_rid, axim_rdata, axim_rresp, axim_rlast, axim_ruser};
  assign {axis_rid, axis_rdata, axis_rresp, axis_rlast, axis_ruser} = r_snk;

  axi_reg_slice_cell #(.P_WIDTH(AXW), .P_MODE(P_AW_MODE)) u_aw (
    .clk(clk), .rst_n(rst_n),
    .src_valid(axis_awvalid), .src_ready(axis_awready), .src_data(aw_src),
    .snk_valid(axim_awvalid), .snk_ready(axim_awready), .snk_data(aw_snk)
  );

  axi_reg_slice_cell #(.P_WIDTH(WW), .P_MODE(P_W_MODE)) u_w (
    .clk(clk), .rst_n(rst_n),
    .src_valid(axis_wvalid), .src_ready(axis_wready), .src_data(w_src),
    .snk_valid(axim_wvalid), .snk_ready(axim_wready), .snk_data(w_snk)
  );

  axi_reg_slice_cell #(.P_WIDTH(BW), .P_MODE(P_B_MODE)) u_b (
    .clk(clk), .rst_n(rst_n),
    .src_valid(axim_bvalid), .src_ready(axim_bready), .src_data(b_src),
    .snk_valid(axis_bvalid), .snk_ready(axis_bready), .snk_data(b_snk)
  );

  axi_reg_slice_cell #(.P_WIDTH(AXW), .P_MODE(P_AR_MODE)) u_ar (
    .clk(clk), .rst_n(rst_n),
    .src_valid(axis_arvalid), .src_ready(axis_arready), .src_data(ar_src),
    .snk_valid(axim_arvalid), .snk_ready(axim_arready), .snk_data(ar_snk)
  );

  axi_reg_slice_cell #(.P_WIDTH(RW), .P_MODE(P_R_MODE)) u_r (
    .clk(clk), .rst_n(rst_n),
    .src_valid(axim_rvalid), .src_ready(axim_rready), .src_data(r_src),
    .snk_valid(axis_rvalid), .snk_ready(axis_rready), .snk_data(r_snk)
  );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice: AW/W/R skid slices, B feed-through,
// AR forward register, directed and random-stall traffic.

module tb_axi_reg_slice;

  logic        clk;
  logic        rst_n;
  logic [31:0] axis_awaddr;
  logic [7:0]  axis_awlen;
  logic [2:0]  axis_awsize;
  logic [1:0]  axis_awburst;
  logic [4:0]  axis_awid;
  logic        axis_awlock;
  logic [3:0]  axis_awcache;
  logic [2:0]  axis_awprot;
  logic [0:0]  axis_awuser;
  logic        axis_awvalid, axis_awready;
  logic [4:0]  axis_wid;
  logic [63:0] axis_wdata;
  logic [7:0]  axis_wstrb;
  logic        axis_wlast;
  logic [0:0]  axis_wuser;
  logic        axis_wvalid, axis_wready;
  logic [4:0]  axis_bid;
  logic [1:0]  axis_bresp;
  logic [0:0]  axis_buser;
  logic        axis_bvalid, axis_bready;
  logic [4:0]  axis_arid;
  logic [31:0] axis_araddr;
  logic [7:0]  axis_arlen;
  logic [2:0]  axis_arsize;
  logic [1:0]  axis_arburst;
  logic        axis_arlock;
  logic [3:0]  axis_arcache;
  logic [2:0]  axis_arprot;
  logic [0:0]  axis_aruser;
  logic        axis_arvalid, axis_arready;
  logic [4:0]  axis_rid;
  logic [63:0] axis_rdata;
  logic [1:0]  axis_rresp;
  logic        axis_rlast;
  logic [0:0]  axis_ruser;
  logic        axis_rvalid, axis_rready;
  logic [31:0] axim_awaddr;
  logic [7:0]  axim_awlen;
  logic [2:0]  axim_awsize;
  logic [1:0]  axim_awburst;
  logic [4:0]  axim_awid;
  logic        axim_awlock;
  logic [3:0]  axim_awcache;
  logic [2:0]  axim_awprot;
  logic [0:0]  axim_awuser;
  logic        axim_awvalid, axim_awready;
  logic [4:0]  axim_wid;
  logic [63:0] axim_wdata;
  logic [7:0]  axim_wstrb;
  logic        axim_wlast;
  logic [0:0]  axim_wuser;
  logic        axim_wvalid, axim_wready;
  logic [4:0]  axim_bid;
  logic [1:0]  axim_bresp;
  logic [0:0]  axim_buser;
  logic        axim_bvalid, axim_bready;
  logic [4:0]  axim_arid;
  logic [31:0] axim_araddr;
  logic [7:0]  axim_arlen;
  logic [2:0]  axim_arsize;
  logic [1:0]  axim_arburst;
  logic        axim_arlock;
  logic [3:0]  axim_arcache;
  logic [2:0]  axim_arprot;
  logic [0:0]  axim_aruser;
  logic        axim_arvalid, axim_arready;
  logic [4:0]  axim_rid;
  logic [63:0] axim_rdata;
  logic [1:0]  axim_rresp;
  logic        axim_rlast;
  logic [0:0]  axim_ruser;
  logic        axim_rvalid, axim_rready;

  int n_chk;
  int n_err;

  axi_reg_slice #(
    .P_B_MODE (0),
    .P_AR_MODE(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .axis_awaddr(axis_awaddr),
    .axis_awlen(axis_awlen),
    .axis_awsize(axis_awsize),
    .axis_awburst(axis_awburst),
    .axis_awid(axis_awid),
    .axis_awlock(axis_awlock),
    .axis_awcache(axis_awcache),
    .axis_awprot(axis_awprot),
    .axis_awuser(axis_awuser),
    .axis_awvalid(axis_awvalid),
    .axis_awready(axis_awready),
    .axis_wid(axis_wid),
    .axis_wdata(axis_wdata),
    .axis_wstrb(axis_wstrb),
    .axis_wlast(axis_wlast),
    .axis_wuser(axis_wuser),
    .axis_wvalid(axis_wvalid),
    .axis_wready(axis_wready),
    .axis_bid(axis_bid),
    .axis_bresp(axis_bresp),
    .axis_buser(axis_buser),
    .axis_bvalid(axis_bvalid),
    .axis_bready(axis_bready),
    .axis_arid(axis_arid),
    .axis_araddr(axis_araddr),
    .axis_arlen(axis_arlen),
    .axis_arsize(axis_arsize),
    .axis_arburst(axis_arburst),
    .axis_arlock(axis_arlock),
    .axis_arcache(axis_arcache),
    .axis_arprot(axis_arprot),
    .axis_aruser(axis_aruser),
    .axis_arvalid(axis_arvalid),
    .axis_arready(axis_arready),
    .axis_rid(axis_rid),
    .axis_rdata(axis_rdata),
    .axis_rresp(axis_rresp),
    .axis_rlast(axis_rlast),
    .axis_ruser(axis_ruser),
    .axis_rvalid(axis_rvalid),
    .axis_rready(axis_rready),
    .axim_awaddr(axim_awaddr),
    .axim_awlen(axim_awlen),
    .axim_awsize(axim_awsize),
    .axim_awburst(axim_awburst),
    .axim_awid(axim_awid),
    .axim_awlock(axim_awlock),
    .axim_awcache(axim_awcache),
    .axim_awprot(axim_awprot),
    .axim_awuser(axim_awuser),
    .axim_awvalid(axim_awvalid),
    .axim_awready(axim_awready),
    .axim_wid(axim_wid),
    .axim_wdata(axim_wdata),
    .axim_wstrb(axim_wstrb),
    .axim_wlast(axim_wlast),
    .axim_wuser(axim_wuser),
    .axim_wvalid(axim_wvalid),
    .axim_wready(axim_wready),
    .axim_bid(axim_bid),
    .axim_bresp(axim_bresp),
    .axim_buser(axim_buser),
    .axim_bvalid(axim_bvalid),
    .axim_bready(axim_bready),
    .axim_arid(axim_arid),
    .axim_araddr(axim_araddr),
    .axim_arlen(axim_arlen),
    .axim_arsize(axim_arsize),
    .axim_arburst(axim_arburst),
    .axim_arlock(axim_arlock),
    .axim_arcache(axim_arcache),
    .axim_arprot(axim_arprot),
    .axim_aruser(axim_aruser),
    .axim_arvalid(axim_arvalid),
    .axim_arready(axim_arready),
    .axim_rid(axim_rid),
    .axim_rdata(axim_rdata),
    .axim_rresp(axim_rresp),
    .axim_rlast(axim_rlast),
    .axim_ruser(axim_ruser),
    .axim_rvalid(axim_rvalid),
    .axim_rready(axim_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat payload patterns for the random test, indexed by beat number.
  function automatic logic [127:0] aw_pat(input int n);
    return 128'({32'h1000_0000 + 32'(n), n[7:0], n[4:0], n[0]});
  endfunction
  function automatic logic [127:0] w_pat(input int n);
    return 128'({n, ~n, n[7:0], n[0], n[4:0]});
  endfunction
  function automatic logic [127:0] b_pat(input int n);
    return 128'({n[4:0], n[1:0], n[2]});
  endfunction
  function automatic logic [127:0] ar_pat(input int n);
    return 128'({32'h2000_0000 ^ 32'(n), ~n[7:0], n[4:0]});
  endfunction
  function automatic logic [127:0] r_pat(input int n);
    return 128'({~n, n, n[4:0], n[3:2], n[1]});
  endfunction

  task automatic idle();
    axis_awvalid = 0; axis_wvalid = 0; axim_bvalid = 0;
    axis_arvalid = 0; axim_rvalid = 0;
    axim_awready = 0; axim_wready = 0; axis_bready = 0;
    axim_arready = 0; axis_rready = 0;
  endtask

  int          sn[5];
  int          rn[5];
  logic [4:0]  v, acc, pop, rdy, srdy, svld;
  logic [127:0] tmp;
  logic [8:0]  got_q[$];
  logic [13:0] rsched;
  int          k;
  int          cyc;
  logic        a;

  task automatic drive_src();
    tmp = aw_pat(sn[0]);
    axis_awvalid = v[0];
    {axis_awaddr, axis_awlen, axis_awid, axis_awuser} = tmp[45:0];
    tmp = w_pat(sn[1]);
    axis_wvalid = v[1];
    {axis_wdata, axis_wstrb, axis_wlast, axis_wid} = tmp[77:0];
    tmp = b_pat(sn[2]);
    axim_bvalid = v[2];
    {axim_bid, axim_bresp, axim_buser} = tmp[7:0];
    tmp = ar_pat(sn[3]);
    axis_arvalid = v[3];
    {axis_araddr, axis_arlen, axis_arid} = tmp[44:0];
    tmp = r_pat(sn[4]);
    axim_rvalid = v[4];
    {axim_rdata, axim_rid, axim_rresp, axim_rlast} = tmp[71:0];
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 0;
    idle();
    axis_awaddr = 0; axis_awlen = 0; axis_awsize = 0; axis_awburst = 0;
    axis_awid = 0; axis_awlock = 0; axis_awcache = 0; axis_awprot = 0;
    axis_awuser = 0;
    axis_wid = 0; axis_wdata = 0; axis_wstrb = 0; axis_wlast = 0;
    axis_wuser = 0;
    axim_bid = 0; axim_bresp = 0; axim_buser = 0;
    axis_arid = 0; axis_araddr = 0; axis_arlen = 0; axis_arsize = 0;
    axis_arburst = 0; axis_arlock = 0; axis_arcache = 0; axis_arprot = 0;
    axis_aruser = 0;
    axim_rid = 0; axim_rdata = 0; axim_rresp = 0; axim_rlast = 0;
    axim_ruser = 0;

    // reset with a pending AW beat
    axis_awvalid = 1;
    axis_awaddr  = 32'hA0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awvalid", axim_awvalid, 1'b0);
    chk("rst_awready", axis_awready, 1'b1);
    chk("rst_arready", axis_arready, 1'b1);
    chk("rst_rvalid", axis_rvalid, 1'b0);
    chk("rst_wready", axis_wready, 1'b1);
    rst_n = 1;
    @(posedge clk); #1;
    chk("first_beat", {axim_awvalid, axim_awaddr}, {1'b1, 32'hA0});
    chk("one_awready", axis_awready, 1'b1);
    axis_awvalid = 0;
    axim_awready = 1;
    @(posedge clk); #1;
    chk("aw_drain", axim_awvalid, 1'b0);
    idle();

    // W streaming, 16 beats under constant ready
    axim_wready = 1;
    for (int i = 0; i < 16; i++) begin
      axis_wvalid = 1;
      axis_wdata  = 64'(i);
      axis_wlast  = (i == 15);
      @(posedge clk); #1;
      chk("w_stream", {axim_wvalid, axim_wlast, axim_wdata, axis_wready},
          {1'b1, i == 15, 64'(i), 1'b1});
    end
    axis_wvalid = 0;
    axis_wlast  = 0;
    @(posedge clk); #1;
    chk("w_end", axim_wvalid, 1'b0);
    idle();

    // R backpressure: sink ready low for cycles 3..5
    rsched = 14'b1111111_000_1111;
    k = 0;
    got_q.delete();
    for (int c = 0; c < 14; c++) begin
      axim_rvalid = (k < 8);
      axim_rdata  = 64'(k);
      axim_rlast  = (k == 7);
      axis_rready = !(c >= 3 && c <= 5);
      #1;
      chk("r_bp_rdy", axim_rready, rsched[c]);
      a = axim_rvalid && axim_rready;
      if (axis_rvalid && axis_rready)
        got_q.push_back({axis_rlast, axis_rdata[7:0]});
      @(posedge clk); #1;
      if (a) k++;
    end
    chk("r_bp_cnt", 128'(got_q.size()), 128'(8));
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk("r_bp_ord", got_q[i], {i == 7, 8'(i)});
    idle();

    // B feed-through: same-cycle valid/payload and ready
    axim_bvalid = 1;
    axim_bid    = 5'h0A;
    axim_bresp  = 2'b10;
    axis_bready = 0;
    #1;
    chk("b_pass", {axis_bvalid, axis_bid, axis_bresp, axim_bready},
        {1'b1, 5'h0A, 2'b10, 1'b0});
    axis_bready = 1;
    #1;
    chk("b_rdy", axim_bready, 1'b1);
    idle();
    @(posedge clk); #1;

    // AR forward register
    axis_arvalid = 1;
    axis_araddr  = 32'h1000_0000;
    axim_arready = 0;
    #1;
    chk("ar_empty", {axim_arvalid, axis_arready}, 2'b01);
    @(posedge clk); #1;
    chk("ar_fwd", {axim_arvalid, axim_araddr}, {1'b1, 32'h1000_0000});
    chk("ar_full_rdy", axis_arready, 1'b0);
    axis_arvalid = 0;
    axim_arready = 1;
    #1;
    chk("ar_pop_rdy", axis_arready, 1'b1);
    @(posedge clk); #1;
    axim_arready = 0;
    #1;
    chk("ar_drain", {axim_arvalid, axis_arready}, 2'b01);
    idle();

    // fill AW to FULL, then reset mid-operation
    axis_awvalid = 1;
    axis_awaddr  = 32'hBEEF;
    @(posedge clk); #1;
    axis_awaddr = 32'hBEF0;
    @(posedge clk); #1;
    axis_awvalid = 0;
    #1;
    chk("aw_full", {axim_awvalid, axis_awready, axim_awaddr},
        {2'b10, 32'hBEEF});
    rst_n = 0;
    #1;
    chk("mid_rst", {axim_awvalid, axis_awready, axim_wvalid,
                    axis_rvalid, axim_arvalid}, 5'b01000);
    @(posedge clk); #1;
    rst_n = 1;
    axim_awready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_stale", axim_awvalid, 1'b0);
    end
    idle();
    @(posedge clk); #1;

    // random stall on all channels
    for (int c = 0; c < 5; c++) begin
      sn[c] = 0;
      rn[c] = 0;
    end
    v   = '0;
    acc = '0;
    cyc = 0;
    while ((rn[0] < 1000 || rn[1] < 1000 || rn[2] < 1000 ||
            rn[3] < 1000 || rn[4] < 1000) && cyc < 20000) begin
      for (int c = 0; c < 5; c++) begin
        if (acc[c]) sn[c]++;
        if (!v[c] || acc[c])
          v[c] = (sn[c] < 1000) && ($urandom_range(0, 1) == 1);
      end
      drive_src();
      rdy = 5'($urandom_range(0, 31));
      {axis_rready, axim_arready, axis_bready, axim_wready,
       axim_awready} = rdy;
      #1;
      srdy = {axim_rready, axis_arready, axim_bready, axis_wready,
              axis_awready};
      axim_awready = ~axim_awready;
      axim_wready  = ~axim_wready;
      axis_rready  = ~axis_rready;
      #1;
      chk("no_comb_rdy", {axis_awready, axis_wready, axim_rready},
          {srdy[0], srdy[1], srdy[4]});
      axim_awready = ~axim_awready;
      axim_wready  = ~axim_wready;
      axis_rready  = ~axis_rready;
      #1;
      svld = {axis_rvalid, axim_arvalid, axis_bvalid, axim_wvalid,
              axim_awvalid};
      acc = v & srdy;
      pop = svld & rdy;
      if (pop[0]) begin
        chk("rnd_aw", 128'({axim_awaddr, axim_awlen, axim_awid,
                            axim_awuser}), aw_pat(rn[0]));
        rn[0]++;
      end
      if (pop[1]) begin
        chk("rnd_w", 128'({axim_wdata, axim_wstrb, axim_wlast,
                           axim_wid}), w_pat(rn[1]));
        rn[1]++;
      end
      if (pop[2]) begin
        chk("rnd_b", 128'({axis_bid, axis_bresp, axis_buser}),
            b_pat(rn[2]));
        rn[2]++;
      end
      if (pop[3]) begin
        chk("rnd_ar", 128'({axim_araddr, axim_arlen, axim_arid}),
            ar_pat(rn[3]));
        rn[3]++;
      end
      if (pop[4]) begin
        chk("rnd_r", 128'({axis_rdata, axis_rid, axis_rresp,
                           axis_rlast}), r_pat(rn[4]));
        rn[4]++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    for (int c = 0; c < 5; c++)
      chk("rnd_count", 128'(rn[c]), 128'(1000));
    idle();
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
